// File: rtl/formula_sweep_driver.sv
// formula_sweep_driver
// Walks every assignment of the free formula variables on a registered bus,
// samples the formula's single-bit output after a settle window, and reports
// the satisfying count, the first counterexample and an overall pass flag.
module formula_sweep_driver #(
   parameter int N_VARS = 19,
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              stop_on_fail,
   input  logic [N_VARS-1:0] mask_i,
   input  logic [N_VARS-1:0] fix_i,
   output logic [N_VARS-1:0] assign_o,
   input  logic              formula_i,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              cex_valid,
   output logic [N_VARS-1:0] cex,
   output logic [N_VARS:0]   sat_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Settle counter counts down from SETTLE-1; a sample is taken when it is 0.
   localparam int              CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
   localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
   localparam logic [N_VARS-1:0] VAR_ONE   = N_VARS'(1);
   localparam logic [N_VARS:0]   SAT_ONE   = (N_VARS + 1)'(1);

   logic [1:0]        state;
   logic [N_VARS-1:0] mask_q;
   logic [N_VARS-1:0] fix_q;
   logic              sof_q;
   logic [CW-1:0]     settle_cnt;

   logic              last;
   logic              fail_new;
   logic [N_VARS-1:0] next_assign;

   // Fixed bits are forced to 1 so the +1 carry ripples straight across them,
   // making the free bits count in binary order; fixed values are then restored.
   assign next_assign = (((assign_o | mask_q) + VAR_ONE) & ~mask_q) | (fix_q & mask_q);
   assign last        = &(assign_o | mask_q);
   assign fail_new    = !formula_i && !cex_valid;

   assign busy = (state == S_HOLD);
   assign done = (state == S_DONE);

   // Sweep FSM and result datapath: latch at start, sample/advance in HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         mask_q     <= '0;
         fix_q      <= '0;
         sof_q      <= 1'b0;
         settle_cnt <= '0;
         assign_o   <= '0;
         sat_count  <= '0;
         cex        <= '0;
         cex_valid  <= 1'b0;
         pass       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register reads the
         // pre-edge values of the others (e.g. cex captures the held assign_o).
         case (state)
            S_IDLE: begin
               // start takes priority over abort simply because abort is not looked at here
               if (start) begin
                  mask_q     <= mask_i;
                  fix_q      <= fix_i;
                  sof_q      <= stop_on_fail;
                  assign_o   <= fix_i & mask_i;
                  sat_count  <= '0;
                  cex        <= '0;
                  cex_valid  <= 1'b0;
                  pass       <= 1'b0;
                  settle_cnt <= SETTLE_LAST;
                  state      <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (abort) begin
                  // Partial results stay visible; any sample due this edge is dropped.
                  pass  <= 1'b0;
                  state <= S_IDLE;
               end else if (settle_cnt != '0) begin
                  settle_cnt <= settle_cnt - CNT_ONE;
               end else begin
                  if (formula_i) begin
                     sat_count <= sat_count + SAT_ONE;
                  end else if (!cex_valid) begin
                     cex       <= assign_o;
                     cex_valid <= 1'b1;
                  end
                  if (last || (fail_new && sof_q)) begin
                     pass  <= !(cex_valid || fail_new);
                     state <= S_DONE;
                  end else begin
                     assign_o   <= next_assign;
                     settle_cnt <= SETTLE_LAST;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_formula_sweep_driver.sv
// Bench for formula_sweep_driver: two 4-variable instances (SETTLE=1 and 3),
// each driven by a truth-table formula, checked against an enumeration model.
module tb_formula_sweep_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start1 = 1'b0, start3 = 1'b0;
   logic        abort = 1'b0;
   logic        sof = 1'b0;
   logic [3:0]  mask = '0, fix = '0;
   logic [15:0] tt1 = '1, tt3 = '1;

   logic [3:0]  assign1, assign3, cex1, cex3;
   logic [4:0]  sat1, sat3;
   logic        busy1, busy3, done1, done3, pass1, pass3, cexv1, cexv3;
   logic        formula1, formula3;

   int checks = 0;
   int errors = 0;
   int sel = 1;

   int exp_vals[$];
   int e_sat, e_cexv, e_cex, e_pass;

   always #5 clk = ~clk;

   assign formula1 = tt1[assign1];
   assign formula3 = tt3[assign3];

   formula_sweep_driver #(.N_VARS(4), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .stop_on_fail(sof),
      .mask_i(mask), .fix_i(fix), .assign_o(assign1), .formula_i(formula1),
      .busy(busy1), .done(done1), .pass(pass1), .cex_valid(cexv1), .cex(cex1),
      .sat_count(sat1));

   formula_sweep_driver #(.N_VARS(4), .SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort), .stop_on_fail(sof),
      .mask_i(mask), .fix_i(fix), .assign_o(assign3), .formula_i(formula3),
      .busy(busy3), .done(done3), .pass(pass3), .cex_valid(cexv3), .cex(cex3),
      .sat_count(sat3));

   // View of whichever instance the current test is driving
   logic       c_busy, c_done, c_pass, c_cexv;
   logic [3:0] c_assign, c_cex;
   logic [4:0] c_sat;
   assign c_busy   = (sel == 3) ? busy3   : busy1;
   assign c_done   = (sel == 3) ? done3   : done1;
   assign c_pass   = (sel == 3) ? pass3   : pass1;
   assign c_cexv   = (sel == 3) ? cexv3   : cexv1;
   assign c_assign = (sel == 3) ? assign3 : assign1;
   assign c_cex    = (sel == 3) ? cex3    : cex1;
   assign c_sat    = (sel == 3) ? sat3    : sat1;

   typedef struct {
      int          s_sel;   // instance = its SETTLE value
      logic [3:0]  m;
      logic [3:0]  f;
      logic        s;
      logic [15:0] t;
      int          x_sat;
      int          x_pass;
      int          x_cexv;
      int          x_cex;
      int          x_n;     // number of assignments sampled
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference: the sweep visits, in increasing numeric order, every value
   // that agrees with fix on the masked bits.
   task automatic model(input logic [3:0] m, input logic [3:0] f, input logic s,
                        input logic [15:0] t);
      exp_vals.delete();
      e_sat = 0; e_cexv = 0; e_cex = 0;
      for (int v = 0; v < 16; v++) begin
         if ((v[3:0] & m) == (f & m)) begin
            exp_vals.push_back(v);
            if (t[v]) e_sat++;
            else if (e_cexv == 0) begin
               e_cexv = 1;
               e_cex  = v;
               if (s) break;
            end
         end
      end
      e_pass = (e_cexv == 0) ? 1 : 0;
   endtask

   task automatic do_start(input int s_sel);
      @(negedge clk);
      if (s_sel == 3) start3 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
   endtask

   task automatic wait_assign(input logic [3:0] v, input string name);
      int n = 0;
      while (c_assign !== v && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(name, c_assign, v);
   endtask

   task automatic no_done(input string name);
      int n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done1 || done3) n++;
      end
      check(name, n, 0);
   endtask

   task automatic run_sweep(input int s_sel, input logic [3:0] m, input logic [3:0] f,
                            input logic s, input logic [15:0] t,
                            input int x_sat, input int x_pass, input int x_cexv,
                            input int x_cex, input int x_n, input string tag);
      int cyc = 0, dcount = 0, busy_cyc = 0, bad = 0, st;
      logic [3:0] got[$];
      st = s_sel;
      sel = s_sel; mask = m; fix = f; sof = s;
      if (s_sel == 3) tt3 = t; else tt1 = t;
      model(m, f, s, t);
      do_start(s_sel);
      while (cyc < 400 && dcount == 0) begin
         if (c_done) dcount++;
         else begin
            if (c_busy) begin
               busy_cyc++;
               got.push_back(c_assign);
            end
            @(negedge clk);
            cyc++;
         end
      end
      check({tag, ".done"}, dcount, 1);
      check({tag, ".busy_in_done"}, c_busy, 0);
      check({tag, ".busy_cycles"}, busy_cyc, x_n * st);
      for (int i = 0; i < got.size(); i++) begin
         if (i / st >= exp_vals.size() || got[i] != exp_vals[i / st][3:0]) bad++;
      end
      check({tag, ".sequence"}, bad, 0);
      check({tag, ".pass"}, c_pass, x_pass);
      check({tag, ".sat_count"}, c_sat, x_sat);
      check({tag, ".cex_valid"}, c_cexv, x_cexv);
      check({tag, ".cex"}, c_cex, x_cex);
      @(negedge clk);
      check({tag, ".done_pulse"}, {c_done, c_busy}, 2'b00);
      check({tag, ".hold"}, {c_pass, c_sat}, {x_pass[0], x_sat[4:0]});
   endtask

   initial begin
      vecs[0] = '{1, 4'b0000, 4'b0000, 1'b0, 16'hFFFF, 16, 1, 0, 4'h0, 16};
      vecs[1] = '{1, 4'b0000, 4'b0000, 1'b1, 16'hFBFF, 10, 0, 1, 4'hA, 11};
      vecs[2] = '{1, 4'b0101, 4'b0100, 1'b0, 16'hFFFF, 4,  1, 0, 4'h0, 4};
      vecs[3] = '{3, 4'b0000, 4'b0000, 1'b0, 16'h7FFE, 14, 0, 1, 4'h0, 16};
      vecs[4] = '{1, 4'b1111, 4'b1001, 1'b0, 16'hFFFF, 1,  1, 0, 4'h0, 1};
      vecs[5] = '{3, 4'b1111, 4'b1001, 1'b1, 16'hFDFF, 0,  0, 1, 4'h9, 1};

      // Reset state, asserted mid-cycle so both instances start from reset values
      #12;
      check("reset.dut1", {busy1, done1, pass1, cexv1, cex1, sat1, assign1}, '0);
      check("reset.dut3", {busy3, done3, pass3, cexv3, cex3, sat3, assign3}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 6; i++) begin
         run_sweep(vecs[i].s_sel, vecs[i].m, vecs[i].f, vecs[i].s, vecs[i].t,
                   vecs[i].x_sat, vecs[i].x_pass, vecs[i].x_cexv, vecs[i].x_cex,
                   vecs[i].x_n, $sformatf("vec%0d", i));
      end

      // Randomized sweeps against the enumeration model
      for (int i = 0; i < 24; i++) begin
         logic [3:0]  m, f;
         logic        s;
         logic [15:0] t;
         int          ss;
         m  = 4'($urandom);
         f  = 4'($urandom);
         s  = 1'($urandom);
         t  = (i % 3 == 0) ? 16'($urandom) : 16'($urandom | $urandom | $urandom);
         ss = ($urandom_range(0, 1) == 0) ? 1 : 3;
         model(m, f, s, t);
         run_sweep(ss, m, f, s, t, e_sat, e_pass, e_cexv, e_cex, exp_vals.size(),
                   $sformatf("rand%0d", i));
      end

      // start mid-sweep is ignored; reset mid-sweep clears everything, no done
      sel = 1; mask = '0; fix = '0; sof = 1'b0; tt1 = 16'hFFFF;
      do_start(1);
      wait_assign(4'd5, "mid.reach5");
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("mid.start_ignored", {busy1, assign1}, {1'b1, 4'd6});
      wait_assign(4'd7, "mid.reach7");
      check("mid.partial_sat", sat1, 5'd7);
      #2 rst_n = 1'b0;
      #1;
      check("mid.reset_outputs", {busy1, done1, pass1, cexv1, cex1, sat1, assign1}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      no_done("mid.reset_no_done");

      // abort beats the sample on the same edge; partial results kept
      do_start(1);
      wait_assign(4'd3, "abort.reach3");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort.state", {busy1, done1, pass1, assign1}, {3'b000, 4'd3});
      check("abort.sat_partial", sat1, 5'd3);
      no_done("abort.no_done");

      // abort together with start in IDLE: start wins
      mask = 4'b1111; fix = 4'b1001;
      @(negedge clk);
      start1 = 1'b1; abort = 1'b1;
      @(negedge clk);
      start1 = 1'b0; abort = 1'b0;
      check("startabort.busy", {busy1, assign1}, {1'b1, 4'b1001});
      @(negedge clk);
      check("startabort.done", {done1, pass1, sat1}, {2'b11, 5'd1});
      // start during DONE is ignored
      mask = 4'b0000; fix = 4'b0000;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("startdone.ignored", {busy1, done1, assign1, sat1}, {2'b00, 4'b1001, 5'd1});
      @(negedge clk);
      check("startdone.idle", {busy1, done1}, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
